// File: rtl/lcd_pkg.sv
// Shared types, command bytes and init ROM for the HD44780-style LCD controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      INIT_WAIT = 3'd0,
      SETUP     = 3'd1,
      PULSE     = 3'd2,
      HOLD      = 3'd3,
      EXEC      = 3'd4,
      IDLE      = 3'd5
   } state_e;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;

   localparam int         INIT_LEN = 6;
   localparam logic [2:0] LAST_IDX = 3'd5;

   localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] = '{
      CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY
   };

   // Out-of-range indices fall back to function-set, which is harmless to resend.
   function automatic logic [7:0] rom_byte(input logic [2:0] idx);
      return (idx <= LAST_IDX) ? INIT_ROM[idx] : CMD_FUNC_SET;
   endfunction

   // Clear and home need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module lcd_timer #(
   parameter int               CNT_W   = 20,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_value,
   output logic             o_done
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   // Count register: load wins, otherwise decrement and park at zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= RST_VAL;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Drives one timed HD44780 write cycle per accepted byte, after running the
// power-up init sequence from the ROM in lcd_pkg.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int T_PWRUP = 750000,
   parameter int T_AS    = 2,
   parameter int T_PW    = 25,
   parameter int T_H     = 2,
   parameter int T_EXEC  = 2000,
   parameter int T_LONG  = 82000,
   parameter int CNT_W   = 20
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_i,
   input  logic       rs_i,
   input  logic [7:0] data_i,
   output logic       ready_o,
   output logic       init_done_o,
   output logic       drop_o,
   output logic [7:0] lcd_data_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic       lcd_en_o,
   output logic       lcd_on_o
);

   // Timer is loaded with N-1 so that a state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
   localparam logic [CNT_W-1:0] LD_AS    = CNT_W'(T_AS - 1);
   localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW - 1);
   localparam logic [CNT_W-1:0] LD_H     = CNT_W'(T_H - 1);
   localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [2:0]       r_idx;
   logic [2:0]       w_idx_nxt;
   logic [7:0]       r_lcd_data;
   logic [7:0]       w_data_nxt;
   logic             r_lcd_rs;
   logic             w_rs_nxt;
   logic             r_lcd_en;
   logic             w_en_nxt;
   logic             r_ready;
   logic             w_ready_nxt;
   logic             r_init_done;
   logic             w_init_done_nxt;
   logic             r_drop;
   logic             r_lcd_on;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_done;

   lcd_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (LD_PWRUP)
   ) u_timer (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_load  (w_load),
      .i_value (w_load_val),
      .o_done  (w_done)
   );

   // Next-state and next-output decode; outputs are registered from these values.
   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_data_nxt      = r_lcd_data;
      w_rs_nxt        = r_lcd_rs;
      w_en_nxt        = 1'b0;
      w_init_done_nxt = r_init_done;
      w_load          = 1'b0;
      w_load_val      = LD_AS;
      case (r_state)
         INIT_WAIT: begin
            if (w_done) begin
               w_state_nxt = SETUP;
               w_load      = 1'b1;
               w_load_val  = LD_AS;
               w_idx_nxt   = 3'd0;
               w_data_nxt  = rom_byte(3'd0);
               w_rs_nxt    = 1'b0;
            end else begin
               w_state_nxt = INIT_WAIT;
            end
         end
         SETUP: begin
            if (w_done) begin
               w_state_nxt = PULSE;
               w_load      = 1'b1;
               w_load_val  = LD_PW;
               w_en_nxt    = 1'b1;
            end else begin
               w_en_nxt    = 1'b0;
            end
         end
         PULSE: begin
            if (w_done) begin
               w_state_nxt = HOLD;
               w_load      = 1'b1;
               w_load_val  = LD_H;
               w_en_nxt    = 1'b0;
            end else begin
               w_en_nxt    = 1'b1;
            end
         end
         HOLD: begin
            if (w_done) begin
               w_state_nxt = EXEC;
               w_load      = 1'b1;
               w_load_val  = is_long_cmd(r_lcd_rs, r_lcd_data) ? LD_LONG : LD_EXEC;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         EXEC: begin
            if (!w_done) begin
               w_state_nxt = EXEC;
            end else if (r_init_done) begin
               w_state_nxt = IDLE;
            end else if (r_idx == LAST_IDX) begin
               w_state_nxt     = IDLE;
               w_init_done_nxt = 1'b1;
            end else begin
               w_state_nxt = SETUP;
               w_load      = 1'b1;
               w_load_val  = LD_AS;
               w_idx_nxt   = r_idx + 3'd1;
               w_data_nxt  = rom_byte(r_idx + 3'd1);
               w_rs_nxt    = 1'b0;
            end
         end
         IDLE: begin
            if (req_i) begin
               w_state_nxt = SETUP;
               w_load      = 1'b1;
               w_load_val  = LD_AS;
               w_data_nxt  = data_i;
               w_rs_nxt    = rs_i;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = INIT_WAIT;
            w_load      = 1'b1;
            w_load_val  = LD_PWRUP;
         end
      endcase
      w_ready_nxt = (w_state_nxt == IDLE);
   end

   // State and registered outputs; reset clears EN without waiting for a clock.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= INIT_WAIT;
         r_idx       <= 3'd0;
         r_lcd_data  <= 8'h00;
         r_lcd_rs    <= 1'b0;
         r_lcd_en    <= 1'b0;
         r_ready     <= 1'b0;
         r_init_done <= 1'b0;
         r_drop      <= 1'b0;
         r_lcd_on    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_lcd_data  <= w_data_nxt;
         r_lcd_rs    <= w_rs_nxt;
         r_lcd_en    <= w_en_nxt;
         r_ready     <= w_ready_nxt;
         r_init_done <= w_init_done_nxt;
         r_drop      <= req_i & ~r_ready;
         r_lcd_on    <= 1'b1;
      end
   end

   assign ready_o     = r_ready;
   assign init_done_o = r_init_done;
   assign drop_o      = r_drop;
   assign lcd_data_o  = r_lcd_data;
   assign lcd_rs_o    = r_lcd_rs;
   assign lcd_rw_o    = 1'b0;
   assign lcd_en_o    = r_lcd_en;
   assign lcd_on_o    = r_lcd_on;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing (init completes 118 cycles
// after reset release: 10 + 5*16 + 28).
module tb_lcd_ctrl;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b1;
   logic       req_i = 1'b0;
   logic       rs_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       ready_o, init_done_o, drop_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o;
   logic [7:0] lcd_data_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lcd_ctrl #(
      .T_PWRUP (10), .T_AS (2), .T_PW (4), .T_H (2),
      .T_EXEC (8), .T_LONG (20), .CNT_W (20)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_i       (req_i),
      .rs_i        (rs_i),
      .data_i      (data_i),
      .ready_o     (ready_o),
      .init_done_o (init_done_o),
      .drop_o      (drop_o),
      .lcd_data_o  (lcd_data_o),
      .lcd_rs_o    (lcd_rs_o),
      .lcd_rw_o    (lcd_rw_o),
      .lcd_en_o    (lcd_en_o),
      .lcd_on_o    (lcd_on_o)
   );

   task automatic test_reset();
      rst_ni = 1'b1;
      #3;
      rst_ni = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({ready_o, init_done_o, drop_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o} !== 7'b0000000) begin
         fails++;
         $display("FAIL reset_ctrl got %b want 0000000",
                  {ready_o, init_done_o, drop_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o});
      end
      tests++;
      if (lcd_data_o !== 8'h00) begin
         fails++;
         $display("FAIL reset_data got %h want 00", lcd_data_o);
      end
      rst_ni = 1'b1;
   endtask

   // Called right after reset release at a negedge; optionally pulses req_i at cycle 3.
   task automatic test_init(input bit poke_req);
      logic [7:0] exp_rom [0:5];
      int npulse, run, low;
      logic prev_en;
      exp_rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      npulse = 0; run = 0; low = 0; prev_en = 1'b0;
      for (int c = 1; c <= 125; c++) begin
         if (poke_req && c == 3) req_i = 1'b1;
         @(posedge clk);
         #1;
         if (poke_req && c == 3) begin
            req_i = 1'b0;
            tests++;
            if (drop_o !== 1'b1) begin
               fails++;
               $display("FAIL init_drop got %b want 1", drop_o);
            end
         end
         if (poke_req && c == 4) begin
            tests++;
            if (drop_o !== 1'b0) begin
               fails++;
               $display("FAIL init_drop_clear got %b want 0", drop_o);
            end
         end
         if (c == 1) begin
            tests++;
            if (lcd_on_o !== 1'b1 || lcd_rw_o !== 1'b0) begin
               fails++;
               $display("FAIL lcd_on_rw got on=%b rw=%b want on=1 rw=0", lcd_on_o, lcd_rw_o);
            end
         end
         if (lcd_en_o === 1'b1) begin
            if (prev_en !== 1'b1) begin
               tests++;
               if (npulse >= 6) begin
                  fails++;
                  $display("FAIL init_extra_pulse got pulse %0d want 6 total", npulse + 1);
               end else if (lcd_data_o !== exp_rom[npulse] || lcd_rs_o !== 1'b0) begin
                  fails++;
                  $display("FAIL init_byte%0d got %h rs=%b want %h rs=0",
                           npulse, lcd_data_o, lcd_rs_o, exp_rom[npulse]);
               end
               // hold + long exec + setup separates the clear pulse from the next
               if (npulse == 5) begin
                  tests++;
                  if (low != 24) begin
                     fails++;
                     $display("FAIL init_clear_gap got %0d want 24", low);
                  end
               end
               npulse++;
               run = 0;
               low = 0;
            end
            run++;
         end else begin
            if (prev_en === 1'b1) begin
               tests++;
               if (run != 4) begin
                  fails++;
                  $display("FAIL init_en_width got %0d want 4", run);
               end
            end
            low++;
         end
         prev_en = lcd_en_o;
         tests++;
         if (init_done_o !== (c >= 118) || ready_o !== (c >= 118)) begin
            fails++;
            $display("FAIL init_done_c%0d got done=%b ready=%b want %b",
                     c, init_done_o, ready_o, (c >= 118));
         end
      end
      tests++;
      if (npulse != 6) begin
         fails++;
         $display("FAIL init_pulse_count got %0d want 6", npulse);
      end
   endtask

   // Issue one byte from IDLE and check the bus cycle and the busy window.
   task automatic do_xfer(input logic rs, input logic [7:0] d, input int busy);
      int en_cnt;
      en_cnt = 0;
      @(negedge clk);
      req_i = 1'b1; rs_i = rs; data_i = d;
      @(posedge clk);
      #1;
      tests++;
      if (ready_o !== 1'b0 || lcd_data_o !== d || lcd_rs_o !== rs || lcd_en_o !== 1'b0) begin
         fails++;
         $display("FAIL xfer_setup_%h got rdy=%b d=%h rs=%b en=%b want rdy=0 d=%h rs=%b en=0",
                  d, ready_o, lcd_data_o, lcd_rs_o, lcd_en_o, d, rs);
      end
      @(negedge clk);
      req_i = 1'b0; data_i = 8'hFF; rs_i = ~rs;
      for (int i = 1; i <= busy; i++) begin
         @(posedge clk);
         #1;
         if (lcd_en_o === 1'b1) en_cnt++;
         tests++;
         if (lcd_en_o !== (i >= 2 && i <= 5)) begin
            fails++;
            $display("FAIL xfer_en_%h_c%0d got %b want %b", d, i, lcd_en_o, (i >= 2 && i <= 5));
         end
         tests++;
         if (ready_o !== (i == busy)) begin
            fails++;
            $display("FAIL xfer_ready_%h_c%0d got %b want %b", d, i, ready_o, (i == busy));
         end
      end
      tests++;
      if (en_cnt != 4 || lcd_data_o !== d || lcd_rs_o !== rs) begin
         fails++;
         $display("FAIL xfer_end_%h got en=%0d d=%h rs=%b want en=4 d=%h rs=%b",
                  d, en_cnt, lcd_data_o, lcd_rs_o, d, rs);
      end
   endtask

   task automatic test_single();
      do_xfer(1'b1, 8'h41, 16);
   endtask

   task automatic test_long_short();
      do_xfer(1'b0, 8'h01, 28);
      do_xfer(1'b0, 8'h80, 16);
      do_xfer(1'b0, 8'h02, 28);
      do_xfer(1'b0, 8'h03, 28);
      do_xfer(1'b1, 8'h01, 16);
   endtask

   // req held high: accepts land every 17 cycles (16 busy + 1 ready).
   task automatic test_back_to_back();
      logic [7:0] exp_d;
      bit got_ready;
      rs_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         req_i = 1'b1;
         data_i = 8'h30 + 8'(i);
         @(posedge clk);
         #1;
         exp_d = 8'h30 + 8'(17 * (i / 17));
         tests++;
         if (drop_o !== (i % 17 != 0)) begin
            fails++;
            $display("FAIL b2b_drop_c%0d got %b want %b", i, drop_o, (i % 17 != 0));
         end
         tests++;
         if (ready_o !== (i % 17 == 16)) begin
            fails++;
            $display("FAIL b2b_ready_c%0d got %b want %b", i, ready_o, (i % 17 == 16));
         end
         tests++;
         if (lcd_data_o !== exp_d || lcd_rs_o !== 1'b1) begin
            fails++;
            $display("FAIL b2b_data_c%0d got %h rs=%b want %h rs=1", i, lcd_data_o, lcd_rs_o, exp_d);
         end
      end
      @(negedge clk);
      req_i = 1'b0;
      got_ready = 1'b0;
      for (int i = 0; i < 40 && !got_ready; i++) begin
         @(posedge clk);
         #1;
         if (ready_o === 1'b1) got_ready = 1'b1;
      end
      tests++;
      if (!got_ready) begin
         fails++;
         $display("FAIL b2b_drain got ready=0 want ready=1 within 40 cycles");
      end
   endtask

   task automatic test_init_drop();
      test_reset();
      test_init(1'b1);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_i = 1'b1; rs_i = 1'b1; data_i = 8'h55;
      @(posedge clk);
      @(negedge clk);
      req_i = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      tests++;
      if (lcd_en_o !== 1'b1) begin
         fails++;
         $display("FAIL mid_pre_en got %b want 1", lcd_en_o);
      end
      rst_ni = 1'b0;
      #1;
      tests++;
      if (lcd_en_o !== 1'b0 || ready_o !== 1'b0 || init_done_o !== 1'b0 || lcd_data_o !== 8'h00) begin
         fails++;
         $display("FAIL mid_async got en=%b rdy=%b done=%b d=%h want 0 0 0 00",
                  lcd_en_o, ready_o, init_done_o, lcd_data_o);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      test_init(1'b0);
   endtask

   initial begin
      test_reset();
      test_init(1'b0);
      test_single();
      test_long_short();
      test_back_to_back();
      test_init_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
